led_pattern_gen: RTL and testbench

//  Multi-channel status-LED driver. Successor to the single-bit divide-by-2^N flasher.
//  One shared prescaler and phase counter; each channel independently selects OFF/ON/BLINK/BREATHE.

---
 rtl/led_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel status LED driver (OFF/ON/BLINK/BREATHE, optional burst via LED_BURST_EN)
module led_pattern_gen #(
    parameter int CHANNELS      = 4,
    parameter int PRESCALE_BITS = 16,
    parameter int PHASE_BITS    = 8,
    parameter int PWM_BITS      = 6,
    parameter int BURST_COUNT   = 3,
    parameter int BURST_TICKS   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   trig,
    output logic [CHANNELS-1:0]   led,
    output logic [CHANNELS-1:0]   busy
);

    logic [PRESCALE_BITS-1:0] presc;
    logic [PHASE_BITS-1:0]    phase;
    logic                     tick;

    assign tick = (presc == {PRESCALE_BITS{1'b1}});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc <= '0;
            phase <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (tick) begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Triangle-wave duty: ramps up in the first half of the phase cycle, down in the second.
    logic [PWM_BITS-1:0] ramp;
    logic [PWM_BITS-1:0] duty;
    logic                breathe_on;

    assign ramp       = phase[PHASE_BITS-2 -: PWM_BITS];
    assign duty       = phase[PHASE_BITS-1] ? ~ramp : ramp;
    assign breathe_on = (presc[PWM_BITS-1:0] < duty);

    logic [CHANNELS-1:0] mode_led;

    always_comb begin
        mode_led = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (mode[2*i +: 2])
                2'b00:   mode_led[i] = 1'b0;
                2'b01:   mode_led[i] = 1'b1;
                2'b10:   mode_led[i] = phase[PHASE_BITS-1];
                default: mode_led[i] = breathe_on;
            endcase
        end
    end

    logic [CHANNELS-1:0] burst_drive;

`ifdef LED_BURST_EN
    localparam int TW = (BURST_TICKS > 1) ? $clog2(BURST_TICKS) : 1;
    localparam int FW = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BURST_TICKS - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BURST_COUNT - 1);

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_ON   = 2'd1,
        B_OFF  = 2'd2
    } bstate_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_burst
        bstate_t         state, state_nx;
        logic [TW-1:0]   tcnt, tcnt_nx;
        logic [FW-1:0]   fcnt, fcnt_nx;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state <= B_IDLE;
                tcnt  <= '0;
                fcnt  <= '0;
            end else begin
                state <= state_nx;
                tcnt  <= tcnt_nx;
                fcnt  <= fcnt_nx;
            end
        end

        // A trigger always restarts the burst, even on the final off-phase tick.
        always_comb begin
            state_nx = state;
            tcnt_nx  = tcnt;
            fcnt_nx  = fcnt;
            if (trig[g]) begin
                state_nx = B_ON;
                tcnt_nx  = '0;
                fcnt_nx  = '0;
            end else begin
                case (state)
                    B_ON: begin
                        if (tick) begin
                            if (tcnt == T_LAST) begin
                                state_nx = B_OFF;
                                tcnt_nx  = '0;
                            end else begin
                                tcnt_nx = tcnt + 1'b1;
                            end
                        end
                    end
                    B_OFF: begin
                        if (tick) begin
                            if (tcnt == T_LAST) begin
                                tcnt_nx = '0;
                                if (fcnt == F_LAST) begin
                                    state_nx = B_IDLE;
                                end else begin
                                    fcnt_nx  = fcnt + 1'b1;
                                    state_nx = B_ON;
                                end
                            end else begin
                                tcnt_nx = tcnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign busy[g]        = (state != B_IDLE);
        assign burst_drive[g] = (state == B_ON);
    end
`else
    logic unused_trig;

    assign unused_trig = ^trig;
    assign busy        = '0;
    assign burst_drive = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                led[i] <= busy[i] ? burst_drive[i] : mode_led[i];
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - randomized bench for led_pattern_gen against a tick-counting reference model
module tb_led_pattern_gen;

    localparam int CH  = 4;
    localparam int PB  = 4;
    localparam int PHB = 6;
    localparam int PW  = 4;
    localparam int BC  = 3;
    localparam int BT  = 2;
`ifdef LED_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic            clk;
    logic            reset_n;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   trig;
    logic [CH-1:0]   led;
    logic [CH-1:0]   busy;

    led_pattern_gen #(
        .CHANNELS      (CH),
        .PRESCALE_BITS (PB),
        .PHASE_BITS    (PHB),
        .PWM_BITS      (PW),
        .BURST_COUNT   (BC),
        .BURST_TICKS   (BT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode),
        .trig    (trig),
        .led     (led),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: cycles since reset, plus ticks elapsed since each channel's last trigger.
    int            cyc;
    bit            active [CH];
    int            ticks  [CH];
    logic [CH-1:0] exp_led;
    logic [CH-1:0] exp_busy;

    function automatic bit mode_out(input int m, input int c);
        int presc;
        int phase;
        int s;
        int duty;
        presc = c % (1 << PB);
        phase = (c / (1 << PB)) % (1 << PHB);
        s     = (phase / (1 << (PHB - 1 - PW))) % (1 << PW);
        duty  = (phase >= (1 << (PHB - 1))) ? ((1 << PW) - 1 - s) : s;
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (phase >= (1 << (PHB - 1)));
            default: return (presc < duty);
        endcase
    endfunction

    task automatic step();
        bit tick;
        for (int i = 0; i < CH; i++) begin
            if (!reset_n)       exp_led[i] = 1'b0;
            else if (active[i]) exp_led[i] = ((ticks[i] / BT) % 2) == 0;
            else                exp_led[i] = mode_out(int'(mode[2*i +: 2]), cyc);
        end
        tick = (cyc % (1 << PB)) == ((1 << PB) - 1);
        if (!reset_n) begin
            cyc = 0;
            for (int i = 0; i < CH; i++) begin
                active[i] = 1'b0;
                ticks[i]  = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (BURST_EN && trig[i]) begin
                    active[i] = 1'b1;
                    ticks[i]  = 0;
                end else if (active[i] && tick) begin
                    ticks[i]++;
                    if (ticks[i] == 2 * BC * BT) active[i] = 1'b0;
                end
            end
            cyc++;
        end
        for (int i = 0; i < CH; i++) exp_busy[i] = active[i];
        @(posedge clk);
        @(negedge clk);
        check_eq("led", {28'd0, led}, {28'd0, exp_led});
        check_eq("busy", {28'd0, busy}, {28'd0, exp_busy});
    endtask

    initial begin
        cyc     = 0;
        reset_n = 1'b0;
        mode    = 8'hFF;
        trig    = '0;
        for (int i = 0; i < CH; i++) begin
            active[i] = 1'b0;
            ticks[i]  = 0;
        end
        trig = 4'hF;
        for (int k = 0; k < 5; k++) step();
        trig    = '0;
        mode    = 8'h55;
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) step();
        // ch3 ON, ch2 OFF, ch1 BREATHE, ch0 BLINK; bursts on ch2 only
        mode = {2'b01, 2'b00, 2'b11, 2'b10};
        for (int k = 0; k < 2500; k++) begin
            trig = '0;
            if ($urandom_range(0, 149) == 0) trig[2] = 1'b1;
            step();
        end
        for (int k = 0; k < 6000; k++) begin
            trig = '0;
            reset_n = 1'b1;
            if ($urandom_range(0, 399) == 0) mode = 8'($urandom);
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 99) == 0) trig[i] = 1'b1;
            if ($urandom_range(0, 1499) == 0) reset_n = 1'b0;
            step();
        end
        trig    = '0;
        reset_n = 1'b1;
        mode    = {2'b01, 2'b00, 2'b00, 2'b00};
        for (int k = 0; k < 40; k++) begin
            trig = 4'hF;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
